// File: rtl/axi_ram_pkg.sv
// Shared definitions for the AXI3 RAM responder.
// Holds the burst and response encodings, the FSM state and SRAM owner
// enums, and the per-beat address-advance helper.
package axi_ram_pkg;

  localparam logic [1:0] FIXED       = 2'b00;
  localparam logic [1:0] INCR        = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_RD, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_READ, OWN_WRITE} owner_t;

  // FIXED keeps the address. INCR, WRAP and the reserved encoding all step
  // by the beat size.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    return (burst == FIXED) ? addr : addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/axi_ram_sram.sv
// Single-port synchronous SRAM of 32-bit words with per-byte write enables.
// Ports:
//   clk    rising-edge clock
//   rd_en  read strobe; rdata updates on the next edge and holds otherwise
//   we     byte write enables (lane i = bits 8i+7:8i)
//   addr   word index
//   wdata  write data
//   rdata  registered read data (1-cycle latency)
// Each byte lane is its own array so every lane infers a plain block RAM.
module axi_ram_sram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [0:DEPTH-1];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (we[gi]) lane_mem[addr] <= wdata[8*gi +: 8];
        if (rd_en)  lane_q_reg     <= lane_mem[addr];
      end

      assign rdata[8*gi +: 8] = lane_q_reg;
    end
  endgenerate

endmodule

// File: rtl/axi_ram_responder.sv
// AXI3 slave backing the CPU data path with an on-chip single-port SRAM.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   AR* / R*                     read address and read data channels
//   AW* / W* / B*                write address, write data, write response
//   AR/AW LOCK, CACHE, PROT, WID are accepted and ignored.
// Parameters: MEM_DEPTH_LOG2 (2^N words), BASE_ADDR (byte address of word 0).
// Optional: define AXI_RESP_ERR_EN to return SLVERR for out-of-range
// accesses and WLAST mismatches; otherwise addresses alias and responses
// are always OKAY.
// Reads and writes share the SRAM port; whoever wins the address handshake
// owns it until its final response handshake. Ties go to the channel that
// was not granted last.
module axi_ram_responder
  import axi_ram_pkg::*;
#(
  parameter int          MEM_DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  ARID,
  input  logic [31:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic [1:0]  ARLOCK,
  input  logic [3:0]  ARCACHE,
  input  logic [2:0]  ARPROT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [3:0]  RID,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [3:0]  AWID,
  input  logic [31:0] AWADDR,
  input  logic [7:0]  AWLEN,
  input  logic [2:0]  AWSIZE,
  input  logic [1:0]  AWBURST,
  input  logic [1:0]  AWLOCK,
  input  logic [3:0]  AWCACHE,
  input  logic [2:0]  AWPROT,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [3:0]  WID,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WLAST,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [3:0]  BID,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY
);

  rd_state_t r_state_reg, r_state_next;
  wr_state_t w_state_reg, w_state_next;
  owner_t    owner_reg, last_grant_reg;
  logic      up_reg;  // keeps both READYs low until the first edge after reset

  logic [3:0]  r_id_reg, w_id_reg;
  logic [31:0] r_addr_reg, w_addr_reg;
  logic [7:0]  r_len_reg, r_cnt_reg, w_len_reg, w_cnt_reg;
  logic [2:0]  r_size_reg, w_size_reg;
  logic [1:0]  r_burst_reg, w_burst_reg;
  logic        w_err_reg;

  logic        ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic        r_last, w_last;
  logic [31:0] r_off, w_off;
  logic        r_oor, w_oor, w_beat_err;
  logic        sram_rd_en;
  logic [3:0]  sram_we;
  logic [MEM_DEPTH_LOG2-1:0] sram_addr;
  logic [31:0] sram_rdata;

  assign ARREADY = up_reg && (owner_reg == OWN_NONE) &&
                   (!AWVALID || last_grant_reg == OWN_WRITE);
  assign AWREADY = up_reg && (owner_reg == OWN_NONE) &&
                   (!ARVALID || last_grant_reg == OWN_READ);

  assign ar_hs  = ARVALID && ARREADY;
  assign aw_hs  = AWVALID && AWREADY;
  assign r_hs   = RVALID && RREADY;
  assign w_hs   = WVALID && WREADY;
  assign b_hs   = BVALID && BREADY;
  assign r_last = (r_cnt_reg == r_len_reg);
  assign w_last = (w_cnt_reg == w_len_reg);

  assign r_off = r_addr_reg - BASE_ADDR;
  assign w_off = w_addr_reg - BASE_ADDR;

`ifdef AXI_RESP_ERR_EN
  assign r_oor      = |(r_off >> (MEM_DEPTH_LOG2 + 2));
  assign w_oor      = |(w_off >> (MEM_DEPTH_LOG2 + 2));
  assign w_beat_err = w_oor || (WLAST != w_last);
`else
  assign r_oor      = 1'b0;
  assign w_oor      = 1'b0;
  assign w_beat_err = 1'b0;
`endif

  // Read FSM: one SRAM read per beat, data presented the cycle after.
  always_comb begin
    r_state_next = r_state_reg;
    RVALID       = 1'b0;
    sram_rd_en   = 1'b0;
    case (r_state_reg)
      R_IDLE: if (ar_hs) r_state_next = R_RD;
      R_RD: begin
        sram_rd_en   = 1'b1;
        r_state_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) r_state_next = r_last ? R_IDLE : R_RD;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Write FSM: the beat counter, not WLAST, decides when the burst ends.
  always_comb begin
    w_state_next = w_state_reg;
    WREADY       = 1'b0;
    BVALID       = 1'b0;
    sram_we      = 4'b0000;
    case (w_state_reg)
      W_IDLE: if (aw_hs) w_state_next = W_DATA;
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          if (!w_oor) sram_we = WSTRB;
          if (w_last) w_state_next = W_RESP;
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  assign sram_addr = (owner_reg == OWN_WRITE) ? w_off[MEM_DEPTH_LOG2+1:2]
                                              : r_off[MEM_DEPTH_LOG2+1:2];

  assign RID   = r_id_reg;
  assign RDATA = (RVALID && !r_oor) ? sram_rdata : 32'h0;
  assign RRESP = (RVALID && r_oor) ? RESP_SLVERR : RESP_OKAY;
  assign RLAST = RVALID && r_last;
  assign BID   = w_id_reg;
  assign BRESP = (BVALID && w_err_reg) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_reg    <= R_IDLE;
      w_state_reg    <= W_IDLE;
      owner_reg      <= OWN_NONE;
      last_grant_reg <= OWN_WRITE;
      up_reg         <= 1'b0;
      r_id_reg       <= '0;
      r_addr_reg     <= '0;
      r_len_reg      <= '0;
      r_cnt_reg      <= '0;
      r_size_reg     <= '0;
      r_burst_reg    <= '0;
      w_id_reg       <= '0;
      w_addr_reg     <= '0;
      w_len_reg      <= '0;
      w_cnt_reg      <= '0;
      w_size_reg     <= '0;
      w_burst_reg    <= '0;
      w_err_reg      <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      w_state_reg <= w_state_next;
      up_reg      <= 1'b1;

      if (ar_hs) begin
        owner_reg      <= OWN_READ;
        last_grant_reg <= OWN_READ;
      end else if (aw_hs) begin
        owner_reg      <= OWN_WRITE;
        last_grant_reg <= OWN_WRITE;
      end else if ((r_hs && r_last) || b_hs) begin
        owner_reg <= OWN_NONE;
      end

      if (ar_hs) begin
        r_id_reg    <= ARID;
        r_addr_reg  <= ARADDR;
        r_len_reg   <= ARLEN;
        r_size_reg  <= ARSIZE;
        r_burst_reg <= ARBURST;
        r_cnt_reg   <= '0;
      end else if (r_hs) begin
        r_addr_reg <= next_addr(r_addr_reg, r_size_reg, r_burst_reg);
        r_cnt_reg  <= r_cnt_reg + 8'd1;
      end

      if (aw_hs) begin
        w_id_reg    <= AWID;
        w_addr_reg  <= AWADDR;
        w_len_reg   <= AWLEN;
        w_size_reg  <= AWSIZE;
        w_burst_reg <= AWBURST;
        w_cnt_reg   <= '0;
        w_err_reg   <= 1'b0;
      end else if (w_hs) begin
        w_addr_reg <= next_addr(w_addr_reg, w_size_reg, w_burst_reg);
        w_cnt_reg  <= w_cnt_reg + 8'd1;
        if (w_beat_err) w_err_reg <= 1'b1;
      end
    end
  end

  axi_ram_sram #(.ADDR_W(MEM_DEPTH_LOG2)) u_sram (
    .clk   (clk),
    .rd_en (sram_rd_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (WDATA),
    .rdata (sram_rdata)
  );

  // Inputs and offset bits that carry no meaning for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{ARLOCK, ARCACHE, ARPROT, AWLOCK, AWCACHE, AWPROT,
                           WID, WLAST, r_off, w_off};

endmodule

// File: tb/tb_axi_ram_responder.sv
// Scoreboard bench for axi_ram_responder: a word-array reference model
// computes expected R beats and B responses, a negedge monitor compares.
module tb_axi_ram_responder;

  localparam int          N    = 12;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [3:0]  ARID, AWID, WID, RID, BID;
  logic [31:0] ARADDR, AWADDR, WDATA, RDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE, ARPROT, AWPROT;
  logic [1:0]  ARBURST, AWBURST, ARLOCK, AWLOCK, RRESP, BRESP;
  logic [3:0]  ARCACHE, AWCACHE, WSTRB;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  axi_ram_responder #(.MEM_DEPTH_LOG2(N), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    bit          known;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t       r_q[$];
  bexp_t       b_q[$];
  logic [31:0] mdl_mem   [0:(1<<N)-1];
  bit          mdl_known [0:(1<<N)-1];
  logic [31:0] wd [0:255];
  logic [3:0]  ws [0:255];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int r_seen = 0;
  int b_seen = 0;
  bit mon_en = 0;
  bit rr_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit oor(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
`ifdef AXI_RESP_ERR_EN
    return 64'(off) >= (64'd4 << N);
`else
    return off === 32'hx;  // never true: addresses alias without the error option
`endif
  endfunction

  function automatic logic [N-1:0] idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[N+1:2];
  endfunction

  function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] size,
                                       input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  function automatic void model_read(input logic [3:0] id, input logic [31:0] addr,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic [31:0] a;
    rexp_t e;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.last = (i == int'(len));
      if (oor(a)) begin
        e.data = 32'h0; e.known = 1; e.resp = 2'b10;
      end else begin
        e.data = mdl_mem[idx(a)]; e.known = mdl_known[idx(a)]; e.resp = 2'b00;
      end
      r_q.push_back(e);
      a = step(a, size, burst);
    end
  endfunction

  function automatic void model_write(input logic [3:0] id, input logic [31:0] addr,
                                      input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst, input bit bad_last);
    logic [31:0] a;
    logic [N-1:0] k;
    bit err;
    bexp_t e;
    a = addr;
`ifdef AXI_RESP_ERR_EN
    err = bad_last;
`else
    err = 0;
`endif
    for (int i = 0; i <= int'(len); i++) begin
      if (oor(a)) err = 1;
      else begin
        k = idx(a);
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mdl_mem[k][8*b +: 8] = wd[i][8*b +: 8];
        if (ws[i] == 4'hF) mdl_known[k] = 1;
      end
      a = step(a, size, burst);
    end
    e.id = id; e.resp = err ? 2'b10 : 2'b00;
    b_q.push_back(e);
  endfunction

  // ---------------- bus drivers ----------------
  task automatic bus_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, output int hs_cyc);
    int n, target;
    target = r_seen + int'(len) + 1;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ARREADY && n < 300);
    if (!ARREADY) begin chk("ar_grant_timeout", 64'(ARREADY), 64'd1); ARVALID = 0; hs_cyc = -1; return; end
    @(posedge clk); #1;
    hs_cyc = cyc;
    ARVALID = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!RVALID && n < 20);
    chk("ar_to_rvalid_cycles", 64'(n), 64'd2);
    n = 0;
    while (r_seen < target && n < 3000) begin @(negedge clk); n++; end
    if (r_seen < target) chk("r_done_timeout", 64'(r_seen), 64'(target));
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input bit bad_last,
                        output int hs_cyc);
    int n, target;
    target = b_seen + 1;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!AWREADY && n < 300);
    if (!AWREADY) begin chk("aw_grant_timeout", 64'(AWREADY), 64'd1); AWVALID = 0; hs_cyc = -1; return; end
    @(posedge clk); #1;
    hs_cyc = cyc;
    AWVALID = 0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i > 0 && $urandom_range(3) == 0) begin
        WVALID = 0; @(posedge clk); #1;
      end
      WDATA = wd[i]; WSTRB = ws[i]; WID = 4'($urandom);
      WLAST = (i == int'(len)) && !bad_last; WVALID = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!WREADY && n < 20);
      if (i == 0) chk("aw_to_wready_cycles", 64'(n), 64'd1);
      if (!WREADY) begin WVALID = 0; return; end
      @(posedge clk); #1;
    end
    WVALID = 0; WLAST = 0;
    @(negedge clk);
    chk("w_to_bvalid", 64'(BVALID), 64'd1);
    n = 0;
    while (b_seen < target && n < 3000) begin @(negedge clk); n++; end
    if (b_seen < target) chk("b_done_timeout", 64'(b_seen), 64'(target));
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int c;
    model_read(id, addr, len, size, burst);
    bus_ar(id, addr, len, size, burst, c);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit bad_last);
    int c;
    model_write(id, addr, len, size, burst, bad_last);
    bus_wr(id, addr, len, size, burst, bad_last, c);
  endtask

  // ---------------- ready generators ----------------
  initial begin
    RREADY = 0; BREADY = 0;
    forever begin
      @(posedge clk); #1;
      RREADY = rr_hold ? 1'b0 : ($urandom_range(3) != 0);
      BREADY = ($urandom_range(3) != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    rexp_t re;
    bexp_t be;
    logic prev_rv, prev_rr, prev_bv, prev_br;
    logic [38:0] prev_r;
    logic [5:0]  prev_b;
    prev_rv = 0; prev_rr = 0; prev_bv = 0; prev_br = 0; prev_r = '0; prev_b = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_rv = 0; prev_bv = 0;
      end else begin
        if (prev_rv && !prev_rr)
          chk("r_held_stable", 64'({RVALID, RID, RDATA, RRESP, RLAST}), 64'({1'b1, prev_r}));
        if (prev_bv && !prev_br)
          chk("b_held_stable", 64'({BVALID, BID, BRESP}), 64'({1'b1, prev_b}));
        if (RVALID && RREADY) begin
          if (r_q.size() == 0) chk("r_unexpected", 64'(RVALID), 64'd0);
          else begin
            re = r_q.pop_front();
            chk("r_beat{id,data,resp,last}",
                64'({RID, re.known ? RDATA : 32'h0, RRESP, RLAST}),
                64'({re.id, re.known ? re.data : 32'h0, re.resp, re.last}));
          end
          r_seen++;
        end
        if (BVALID && BREADY) begin
          if (b_q.size() == 0) chk("b_unexpected", 64'(BVALID), 64'd0);
          else begin
            be = b_q.pop_front();
            chk("b_resp{id,resp}", 64'({BID, BRESP}), 64'({be.id, be.resp}));
          end
          b_seen++;
        end
        prev_rv = RVALID; prev_rr = RREADY; prev_r = {RID, RDATA, RRESP, RLAST};
        prev_bv = BVALID; prev_br = BREADY; prev_b = {BID, BRESP};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int ca, cw, n;
    logic [31:0] held, a;
    logic [7:0] len;
    logic [2:0] sz;
    logic [1:0] bu;
    bit bl;

    for (int i = 0; i < (1<<N); i++) begin mdl_mem[i] = '0; mdl_known[i] = 0; end
    resetn = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0;
    ARLOCK = 0; ARCACHE = 0; ARPROT = 0;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
    AWLOCK = 0; AWCACHE = 0; AWPROT = 0;
    WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({ARREADY, AWREADY, RVALID, WREADY, BVALID, RDATA, RID, RRESP,
                              RLAST, BID, BRESP}), 64'd0);

    // Collision on the first cycle after reset: read wins, write sees nothing of it.
    resetn = 1; mon_en = 1;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    model_read(4'd1, 32'h10, 8'd0, 3'd2, 2'b01);
    model_write(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 0);
    fork
      bus_ar(4'd1, 32'h10, 8'd0, 3'd2, 2'b01, ca);
      bus_wr(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 0, cw);
    join
    chk("collision1_read_first", 64'(ca < cw), 64'd1);

    // Second collision: write was granted last, so read wins again and sees DEADBEEF.
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    model_read(4'd1, 32'h10, 8'd0, 3'd2, 2'b01);
    model_write(4'd5, 32'h10, 8'd0, 3'd2, 2'b01, 0);
    fork
      bus_ar(4'd1, 32'h10, 8'd0, 3'd2, 2'b01, ca);
      bus_wr(4'd5, 32'h10, 8'd0, 3'd2, 2'b01, 0, cw);
    join
    chk("collision2_read_first", 64'(ca < cw), 64'd1);
    do_read(4'd2, 32'h10, 8'd0, 3'd2, 2'b01);

    // Byte strobes.
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(4'd6, 32'h20, 8'd0, 3'd2, 2'b01, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(4'd7, 32'h20, 8'd0, 3'd2, 2'b01, 0);
    chk("strobe_model_word", 64'(mdl_mem[8]), 64'h11BB33DD);
    do_read(4'd8, 32'h20, 8'd0, 3'd2, 2'b01);

    // INCR burst of four.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(4'd9, 32'h40, 8'd3, 3'd2, 2'b01, 0);
    do_read(4'd10, 32'h40, 8'd3, 3'd2, 2'b01);

    // Read backpressure: RREADY low for 5 cycles with RVALID up.
    rr_hold = 1;
    model_read(4'd11, 32'h44, 8'd0, 3'd2, 2'b01);
    fork
      bus_ar(4'd11, 32'h44, 8'd0, 3'd2, 2'b01, ca);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!RVALID && n < 50);
        held = RDATA;
        chk("bp_first_data", 64'(held), 64'h2);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_hold", 64'({RVALID, RDATA}), 64'({1'b1, held}));
        end
        rr_hold = 0;
      end
    join

    // Fill words 0..127 so every later read has a known expectation.
    for (int i = 0; i < 128; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'd12, 32'h0, 8'd127, 3'd2, 2'b01, 0);

    // Out-of-range address: SLVERR with the error option, aliases word 0 without.
    do_read(4'd13, 32'h0001_0000, 8'd0, 3'd2, 2'b01);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      a   = 32'($urandom_range(0, 32'h17F));
      if ($urandom_range(7) == 0) a = a + 32'h0001_0000;
      len = 8'($urandom_range(0, 7));
      sz  = 3'($urandom_range(0, 2));
      bu  = 2'($urandom_range(0, 2));
      bl  = ($urandom_range(7) == 0);
      if ($urandom_range(1) == 0) begin
        for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(4'($urandom), a, len, sz, bu, bl);
      end else begin
        do_read(4'($urandom), a, len, sz, bu);
      end
    end

    // Reset in the middle of a read burst.
    rr_hold = 1;
    ARID = 4'd4; ARADDR = 32'h40; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ARREADY && n < 50);
    @(posedge clk); #1;
    ARVALID = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!RVALID && n < 50);
    chk("pre_reset_rvalid", 64'(RVALID), 64'd1);
    @(posedge clk); #1;
    mon_en = 0;
    resetn = 0;
    #1;
    chk("midburst_reset_outputs", 64'({ARREADY, AWREADY, RVALID, WREADY, BVALID, RDATA, RID,
                                       RRESP, RLAST, BID, BRESP}), 64'd0);
    r_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1; rr_hold = 0; mon_en = 1;
    do_read(4'd14, 32'h40, 8'd3, 3'd2, 2'b01);
    chk("queues_drained", 64'(r_q.size() + b_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
